reservation_station_mcdb: RTL

- Next-generation reservation station: parametrised depth, data/address/tag widths and number of CDB broadcast ports.
- Holds dispatched instructions until both source operands are captured, then issues the oldest ready entry to one functional unit through a registered, stallable output stage.
- Sits between dispatch and a functional unit; snoops all CDB ports for wakeup, including same-cycle bypass at dispatch.

---
 rtl/reservation_station_mcdb.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station_mcdb.sv
// Reservation station that wakes entries from several CDB ports and selects the oldest ready entry with an age matrix.
// The selected entry goes to one functional unit through a registered output stage that can be stalled.
package reservation_station_mcdb_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'h03,
    OPCODE_OPIMM  = 7'h13,
    OPCODE_AUIPC  = 7'h17,
    OPCODE_STORE  = 7'h23,
    OPCODE_OP     = 7'h33,
    OPCODE_LUI    = 7'h37,
    OPCODE_BRANCH = 7'h63,
    OPCODE_JALR   = 7'h67,
    OPCODE_JAL    = 7'h6f,
    OPCODE_SYSTEM = 7'h73
  } opcode_t;

endpackage

module reservation_station_mcdb
  import reservation_station_mcdb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int RS_DEPTH   = 8,
  parameter int CDB_DEPTH  = 2
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            i_flush,
  input  logic                            i_rs_en,
  input  opcode_t                         i_rs_opcode,
  input  logic [ADDR_WIDTH-1:0]           i_rs_iaddr,
  input  logic [DATA_WIDTH-1:0]           i_rs_insn,
  input  logic [1:0]                      i_rs_src_rdy,
  input  logic [2*DATA_WIDTH-1:0]         i_rs_src_data,
  input  logic [2*TAG_WIDTH-1:0]          i_rs_src_tag,
  input  logic [TAG_WIDTH-1:0]            i_rs_dst_tag,
  output logic                            o_rs_stall,
  input  logic [CDB_DEPTH-1:0]            i_cdb_en,
  input  logic [CDB_DEPTH*DATA_WIDTH-1:0] i_cdb_data,
  input  logic [CDB_DEPTH*TAG_WIDTH-1:0]  i_cdb_tag,
  input  logic                            i_fu_stall,
  output logic                            o_fu_valid,
  output opcode_t                         o_fu_opcode,
  output logic [ADDR_WIDTH-1:0]           o_fu_iaddr,
  output logic [DATA_WIDTH-1:0]           o_fu_insn,
  output logic [DATA_WIDTH-1:0]           o_fu_src_a,
  output logic [DATA_WIDTH-1:0]           o_fu_src_b,
  output logic [TAG_WIDTH-1:0]            o_fu_tag
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic                  rdy;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } src_t;

  typedef struct packed {
    opcode_t               opcode;
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] insn;
    logic [TAG_WIDTH-1:0]  dst_tag;
    src_t [1:0]            src;
  } slot_t;

  typedef struct packed {
    opcode_t               opcode;
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] insn;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [TAG_WIDTH-1:0]  tag;
  } fu_t;

  typedef struct packed {
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
  } cdb_hit_t;

  localparam fu_t FU_NOP = '{
    opcode: OPCODE_OPIMM,
    iaddr:  '0,
    insn:   NOP_INSN,
    src_a:  '0,
    src_b:  '0,
    tag:    '0
  };

  // Lowest-index port wins when several ports carry the same tag.
  function automatic cdb_hit_t cdb_match(input logic [TAG_WIDTH-1:0] tag);
    cdb_hit_t r;
    r = '0;
    for (int p = CDB_DEPTH - 1; p >= 0; p--) begin
      if (i_cdb_en[p] && (i_cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        r.hit  = 1'b1;
        r.data = i_cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  logic [RS_DEPTH-1:0] empty;
  logic [RS_DEPTH-1:0] older [RS_DEPTH];
  slot_t               slots [RS_DEPTH];
  fu_t                 fu_q;

  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] sel;
  logic [RS_DEPTH-1:0] issuing;
  logic [RS_DEPTH-1:0] target;
  logic                dispatch;
  logic                advance;
  logic                any_ready;
  logic                dup_cdb;
  cdb_hit_t            wake [RS_DEPTH][2];
  cdb_hit_t            byp [2];
  slot_t               disp_slot;
  slot_t               issue_slot;

  assign o_rs_stall = ~|empty;
  assign dispatch   = i_rs_en & ~o_rs_stall & ~i_flush;
  assign advance    = ~o_fu_valid | ~i_fu_stall;
  assign any_ready  = |ready;
  assign issuing    = advance ? sel : '0;
  // Isolates the lowest set bit of empty.
  assign target     = empty & (~empty + RS_DEPTH'(1));

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = ~empty[i] & slots[i].src[0].rdy & slots[i].src[1].rdy;
    end
  end

  always_comb begin
    sel        = '0;
    issue_slot = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      sel[i] = ready[i] & ~|(older[i] & ready);
      if (sel[i]) begin
        issue_slot = slots[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        wake[i][s] = cdb_match(slots[i].src[s].tag);
      end
    end
  end

  always_comb begin
    disp_slot.opcode  = i_rs_opcode;
    disp_slot.iaddr   = i_rs_iaddr;
    disp_slot.insn    = i_rs_insn;
    disp_slot.dst_tag = i_rs_dst_tag;
    for (int s = 0; s < 2; s++) begin
      byp[s]                = cdb_match(i_rs_src_tag[s*TAG_WIDTH +: TAG_WIDTH]);
      disp_slot.src[s].tag  = i_rs_src_tag[s*TAG_WIDTH +: TAG_WIDTH];
      disp_slot.src[s].rdy  = i_rs_src_rdy[s] | byp[s].hit;
      disp_slot.src[s].data = i_rs_src_rdy[s] ? i_rs_src_data[s*DATA_WIDTH +: DATA_WIDTH]
                                              : byp[s].data;
    end
  end

  always_comb begin
    dup_cdb = 1'b0;
    for (int p = 0; p < CDB_DEPTH; p++) begin
      for (int q = p + 1; q < CDB_DEPTH; q++) begin
        if (i_cdb_en[p] && i_cdb_en[q] &&
            (i_cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == i_cdb_tag[q*TAG_WIDTH +: TAG_WIDTH])) begin
          dup_cdb = 1'b1;
        end
      end
    end
  end

  // NOTE: slot payload is not reset; empty[] qualifies every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (dispatch && target[i]) begin
        slots[i] <= disp_slot;
      end else if (!empty[i]) begin
        for (int s = 0; s < 2; s++) begin
          if (!slots[i].src[s].rdy && wake[i][s].hit) begin
            slots[i].src[s].rdy  <= 1'b1;
            slots[i].src[s].data <= wake[i][s].data;
          end
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      empty      <= '1;
      o_fu_valid <= 1'b0;
      fu_q       <= FU_NOP;
      for (int i = 0; i < RS_DEPTH; i++) begin
        older[i] <= '0;
      end
    end else if (i_flush) begin
      empty      <= '1;
      o_fu_valid <= 1'b0;
      fu_q       <= FU_NOP;
    end else begin
      empty <= (empty | issuing) & ~(dispatch ? target : '0);
      // The new slot is younger than every survivor; its column is cleared everywhere.
      if (dispatch) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          older[i] <= target[i] ? (~empty & ~issuing) : (older[i] & ~target);
        end
      end
      if (advance) begin
        o_fu_valid <= any_ready;
        if (any_ready) begin
          fu_q.opcode <= issue_slot.opcode;
          fu_q.iaddr  <= issue_slot.iaddr;
          fu_q.insn   <= issue_slot.insn;
          fu_q.src_a  <= issue_slot.src[0].data;
          fu_q.src_b  <= issue_slot.src[1].data;
          fu_q.tag    <= issue_slot.dst_tag;
        end else begin
          fu_q <= FU_NOP;
        end
      end
    end
  end

  assign o_fu_opcode = fu_q.opcode;
  assign o_fu_iaddr  = fu_q.iaddr;
  assign o_fu_insn   = fu_q.insn;
  assign o_fu_src_a  = fu_q.src_a;
  assign o_fu_src_b  = fu_q.src_b;
  assign o_fu_tag    = fu_q.tag;

  a_unique_cdb_tag: assert property (@(posedge clk) disable iff (!n_rst) !dup_cdb);
  a_onehot_select:  assert property (@(posedge clk) disable iff (!n_rst) $onehot0(sel));

endmodule
